// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - control/status bundle between a cipher core and its round sequencer
// master drives load/step/abort; slave is the sequencer.
interface round_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             load;
  logic [CNT_W-1:0] round_total;
  logic             step;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] round_idx;
  logic [CNT_W-1:0] remaining;
  logic             first_round;
  logic             last_round;
  logic             done;
  logic             cfg_err;

  modport master (
    output load, round_total, step, abort,
    input  busy, round_idx, remaining, first_round, last_round, done, cfg_err
  );

  modport slave (
    input  load, round_total, step, abort,
    output busy, round_idx, remaining, first_round, last_round, done, cfg_err
  );
endinterface

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - programmable round counter for one cipher core
// Tracks the active round index and rounds remaining; reports done and rejected loads.
module round_sequencer #(
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 14
) (
  input  logic               clk,
  input  logic               rst,
  round_sequencer_if.slave   bus
);

  if ((MAX_ROUNDS < 1) || (MAX_ROUNDS > (2**CNT_W) - 1)) begin : g_bad_cfg
    $error("round_sequencer: MAX_ROUNDS out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO  = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] round_idx_q, round_idx_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             cfg_err_q, cfg_err_d;
  logic             legal_load;

  assign legal_load = bus.load && (bus.round_total != ZERO) && (bus.round_total <= MAX_R);

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    remaining_d = remaining_q;
    cfg_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (legal_load) begin
          state_d     = S_RUN;
          round_idx_d = ZERO;
          remaining_d = bus.round_total;
        end else if (bus.load) begin
          cfg_err_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d     = S_IDLE;
          round_idx_d = ZERO;
          remaining_d = ZERO;
        end else begin
          cfg_err_d = bus.load;
          if (bus.step) begin
            if (remaining_q > ONE) begin
              round_idx_d = round_idx_q + ONE;
              remaining_d = remaining_q - ONE;
            end else begin
              remaining_d = ZERO;
              state_d     = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        // A load here starts the next block without an idle bubble; abort drops it.
        state_d     = S_IDLE;
        round_idx_d = ZERO;
        remaining_d = ZERO;
        if (!bus.abort) begin
          if (legal_load) begin
            state_d     = S_RUN;
            remaining_d = bus.round_total;
          end else if (bus.load) begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        round_idx_d = ZERO;
        remaining_d = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_idx_q <= '0;
      remaining_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      remaining_q <= remaining_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.round_idx   = round_idx_q;
  assign bus.remaining   = remaining_q;
  assign bus.first_round = (state_q == S_RUN) && (round_idx_q == ZERO);
  assign bus.last_round  = (state_q == S_RUN) && (remaining_q == ONE);
  assign bus.cfg_err     = cfg_err_q;

endmodule
